// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage hazard unit for a scalar in-order MIPS pipeline.
// Tracks every in-flight GRF write for STAGES stages past D and derives the
// D-stage stall and the per-operand forwarding stage selects. It also owns
// the mult/div busy timer and a saturating count of stalled cycles.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   flush                  exception/eret flush (kills E/M entries, blocks issue)
//   D_valid .. D_md_is_div  decoded attributes of the instruction held in D
//   stall                  freeze PC/F/D and inject a bubble into E
//   fwd_rs_sel/fwd_rt_sel  stage index of youngest producer, 0 = read GRF
//   md_busy                mult/div timer non-zero
//   stall_cnt              saturating count of stalled cycles
module hazard_scoreboard #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned STAGES      = 3,
    parameter int unsigned TNEW_W      = 2,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              D_valid,
    input  logic [REG_AW-1:0] D_A1,
    input  logic [REG_AW-1:0] D_A2,
    input  logic [TNEW_W-1:0] D_rs_Tuse,
    input  logic [TNEW_W-1:0] D_rt_Tuse,
    input  logic              D_RegWrite,
    input  logic [REG_AW-1:0] D_A3,
    input  logic [TNEW_W-1:0] D_Tnew,
    input  logic              D_epc_write,
    input  logic              D_eret,
    input  logic              D_md_use,
    input  logic              D_md_start,
    input  logic              D_md_is_div,
    output logic              stall,
    output logic [2:0]        fwd_rs_sel,
    output logic [2:0]        fwd_rt_sel,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned MD_W   = $clog2(MD_MAX + 1);

    // Record entries; index k is the stage k cycles past D.
    logic              v_q    [1:STAGES];
    logic [REG_AW-1:0] a3_q   [1:STAGES];
    logic [TNEW_W-1:0] tnew_q [1:STAGES];
    logic              epc_q  [1:STAGES];
    logic              v_d    [1:STAGES];
    logic [REG_AW-1:0] a3_d   [1:STAGES];
    logic [TNEW_W-1:0] tnew_d [1:STAGES];
    logic              epc_d  [1:STAGES];

    logic [MD_W-1:0]   md_q, md_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              rs_hit, rt_hit;
    logic [TNEW_W-1:0] rs_tnew, rt_tnew;
    logic              data_rs, data_rt, md_stall, eret_stall, issue;

    // Youngest-match search: walk oldest to youngest so the smallest k wins.
    always_comb begin
        rs_hit     = 1'b0;
        rt_hit     = 1'b0;
        rs_tnew    = '0;
        rt_tnew    = '0;
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        for (int k = STAGES; k >= 1; k--) begin
            if (v_q[k] && (a3_q[k] == D_A1) && (D_A1 != '0)) begin
                rs_hit     = 1'b1;
                rs_tnew    = tnew_q[k];
                fwd_rs_sel = 3'(k);
            end
            if (v_q[k] && (a3_q[k] == D_A2) && (D_A2 != '0)) begin
                rt_hit     = 1'b1;
                rt_tnew    = tnew_q[k];
                fwd_rt_sel = 3'(k);
            end
        end
    end

    always_comb begin
        md_busy    = (md_q != '0);
        data_rs    = rs_hit && (rs_tnew > D_rs_Tuse);
        data_rt    = rt_hit && (rt_tnew > D_rt_Tuse);
        md_stall   = D_md_use && md_busy;
        // mtc0 EPC still in E or M: eret would read a stale EPC.
        eret_stall = D_eret && (epc_q[1] || epc_q[2]);
        stall      = D_valid && !flush && (data_rs || data_rt || md_stall || eret_stall);
        issue      = D_valid && !stall && !flush;
        stall_cnt  = cnt_q;
    end

    always_comb begin
        v_d[1]    = issue && D_RegWrite && (D_A3 != '0);
        a3_d[1]   = D_A3;
        tnew_d[1] = D_Tnew;
        epc_d[1]  = issue && D_epc_write;
        for (int k = 2; k <= STAGES; k++) begin
            v_d[k]    = v_q[k-1];
            a3_d[k]   = a3_q[k-1];
            tnew_d[k] = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TNEW_W'(1);
            epc_d[k]  = epc_q[k-1];
        end
        // E and M hold wrong-path work on a flush; W and beyond have committed.
        if (flush) begin
            v_d[1]   = 1'b0;
            epc_d[1] = 1'b0;
            v_d[2]   = 1'b0;
            epc_d[2] = 1'b0;
        end

        md_d = md_q;
        if (issue && D_md_start) begin
            md_d = D_md_is_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
        end else if (md_q != '0) begin
            md_d = md_q - MD_W'(1);
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= STAGES; k++) begin
                v_q[k]    <= 1'b0;
                a3_q[k]   <= '0;
                tnew_q[k] <= '0;
                epc_q[k]  <= 1'b0;
            end
            md_q  <= '0;
            cnt_q <= '0;
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                v_q[k]    <= v_d[k];
                a3_q[k]   <= a3_d[k];
                tnew_q[k] <= tnew_d[k];
                epc_q[k]  <= epc_d[k];
            end
            md_q  <= md_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the combinational stall controller of the 5-stage MIPS pipeline. It keeps a shifting record of every in-flight register write (A3, Tnew, CP0-EPC write flag) for STAGES stages past D. From that record it computes the D-stage stall and per-operand producer-stage selects. It also owns an internal mult/div busy timer and a saturating stall-cycle counter, so the pipeline no longer supplies stage-local hazard data.

Parameters:
REG_AW, 5, GRF address width
STAGES, 3, number of tracked stages after D (1=E, 2=M, 3=W, ...); legal range 2..7
TNEW_W, 2, width of Tnew/Tuse fields
MULT_CYCLES, 5, busy cycles for mult/multu
DIV_CYCLES, 10, busy cycles for div/divu
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
flush  in  1  exception/eret flush; clears record entries and suppresses D issue this cycle
D_valid  in  1  D holds a real instruction
D_A1  in  REG_AW  rs address read in D
D_A2  in  REG_AW  rt address read in D
D_rs_Tuse  in  TNEW_W  cycles from D until rs is consumed (3 = unused)
D_rt_Tuse  in  TNEW_W  cycles from D until rt is consumed (3 = unused)
D_RegWrite  in  1  D instruction writes GRF
D_A3  in  REG_AW  destination register
D_Tnew  in  TNEW_W  Tnew the instruction will carry while in E (0 = ALU, 1 = load, ...)
D_epc_write  in  1  D instruction is mtc0 to CP0 register 14
D_eret  in  1  D instruction is eret
D_md_use  in  1  D instruction is any mult/div/mfhi/mflo/mthi/mtlo
D_md_start  in  1  D instruction starts mult/div (implies D_md_use)
D_md_is_div  in  1  selects DIV_CYCLES on start
stall  out  1  freeze PC/F/D and inject bubble into E
fwd_rs_sel  out  3  stage index (1..STAGES) of youngest matching producer; 0 = GRF
fwd_rt_sel  out  3  same for rt
md_busy  out  1  mult/div timer non-zero
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Record entry k (1..STAGES): {v, a3, tnew, epc}. On reset all v=0, md counter=0, stall_cnt=0. Outputs are combinational from state and D inputs, so at reset stall=0, fwd_*=0, md_busy=0.
- Issue: entry 1 loads {D_valid&D_RegWrite&(D_A3!=0)&!stall&!flush, D_A3, D_Tnew, D_valid&D_epc_write&!stall&!flush}. Otherwise it loads a bubble (v=0, epc=0).
- Shift: entry k+1 <= entry k with tnew saturating-decremented (0 stays 0). Entry STAGES falls off.
- Flush: clears v and epc of entries 1..2 (E, M) only. Entries 3+ have committed.
- Match: operand rX matches entry k iff v_k && a3_k==A_X && A_X!=0. Only the youngest match (smallest k) counts.
- fwd_X_sel = k of the youngest match, else 0. It is independent of tnew.
- Data stall X: youngest match exists && tnew_k > D_X_Tuse.
- md stall: D_md_use && md_busy.
- eret stall: D_eret && any entry k in {1,2} has epc=1.
- stall = D_valid && !flush && (data_rs | data_rt | md | eret).
- md timer: on an edge with D_valid&D_md_start&!stall&!flush, load MULT_CYCLES or DIV_CYCLES. Otherwise decrement if non-zero. md_busy = (timer!=0). Flush does not clear a running timer.
- stall_cnt increments on every cycle with stall=1 and holds at all-ones.
- Reset mid-operation clears everything on that edge regardless of other inputs. Reset has priority over flush, and flush has priority over issue.

Test Plan:
- Load-use: lw $8 (D_Tnew=1) issued, next D addu reading $8 with Tuse=0 -> stall=1 for 1 cycle, then fwd_rs_sel=2, stall_cnt=1.
- ALU chain: addu $3 (Tnew=0), then D reads $3 with Tuse=0 -> stall=0, fwd_rs_sel=1. Next cycle with an unrelated D, fwd points to 2.
- Youngest wins: writes to $5 sit in entries 1 and 3 -> fwd_rt_sel=1. Reading $0 -> no stall, sel=0.
- mult/div: div starts (D_md_is_div=1), then mflo in D -> md_busy high, stall=1 for 10 cycles after the div leaves D, released the cycle timer reads 0.
- eret: mtc0 $14 in entry 1, eret in D -> stall for 2 cycles. Asserting flush instead clears the record and drops stall at once.
- Saturation/reset: CNT_W=4, hold stall for 20 cycles -> stall_cnt=15. Synchronous reset mid-run -> all outputs 0 the next cycle.
